hex_keypad_scan: RTL and testbench

HEX_KEYPAD_SCAN -- requirements
Module: hex_keypad_scan

---
 rtl/hex_keypad_scan.sv | 140 ++++++++++++++
 tb/tb_hex_keypad_scan.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/hex_keypad_scan.sv
// 4x4 active-low keypad scanner: walks the columns, debounces press and release,
// and keeps a four-digit history of accepted key codes (hex0 newest).
module hex_keypad_scan #(
    parameter int DWELL    = 1024,
    parameter int DEBOUNCE = 500000
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] col,
    input  logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [3:0] hex3,
    output logic [3:0] hex2,
    output logic [3:0] hex1,
    output logic [3:0] hex0
);
    localparam int CNT_MAX = (DWELL > DEBOUNCE) ? DWELL : DEBOUNCE;
    localparam int CW      = $clog2(CNT_MAX);
    localparam logic [CW-1:0] DWELL_END = CW'(DWELL - 1);
    localparam logic [CW-1:0] DEB_END   = CW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {SCAN, DEB_PRESS, PRESSED, DEB_REL} state_t;

    state_t        state, state_n;
    logic [3:0]    sync1, srow;
    logic [3:0]    lrow, lrow_n;
    logic [1:0]    c, c_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          accept, rel_done;
    logic [1:0]    r_idx;

    always_ff @(posedge clk) begin
        if (!reset) state <= SCAN;
        else        state <= state_n;
    end

    // Every terminal count clears cnt, so it never needs to wrap.
    always_comb begin
        state_n  = state;
        c_n      = c;
        cnt_n    = cnt;
        lrow_n   = lrow;
        accept   = 1'b0;
        rel_done = 1'b0;
        case (state)
            SCAN: begin
                if (cnt == DWELL_END) begin
                    cnt_n = '0;
                    if (srow == 4'hF) begin
                        c_n = c + 2'd1;
                    end else begin
                        lrow_n  = srow;
                        state_n = DEB_PRESS;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DEB_PRESS: begin
                if (srow != lrow) begin
                    state_n = SCAN;
                    c_n     = c + 2'd1;
                    cnt_n   = '0;
                end else if (cnt == DEB_END) begin
                    state_n = PRESSED;
                    cnt_n   = '0;
                    accept  = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (srow == 4'hF) begin
                    state_n = DEB_REL;
                    cnt_n   = '0;
                end
            end
            DEB_REL: begin
                if (srow != 4'hF) begin
                    state_n = PRESSED;
                    cnt_n   = '0;
                end else if (cnt == DEB_END) begin
                    state_n  = SCAN;
                    c_n      = c + 2'd1;
                    cnt_n    = '0;
                    rel_done = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = SCAN;
        endcase
    end

    // Lowest low row wins; scanning downward lets the last hit be the lowest index.
    always_comb begin
        r_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!lrow[i]) r_idx = 2'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1     <= 4'hF;
            srow      <= 4'hF;
            c         <= 2'd0;
            cnt       <= '0;
            lrow      <= 4'hF;
            col       <= 4'b1110;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            hex3      <= 4'h0;
            hex2      <= 4'h0;
            hex1      <= 4'h0;
            hex0      <= 4'h0;
        end else begin
            sync1     <= row;
            srow      <= sync1;
            c         <= c_n;
            cnt       <= cnt_n;
            lrow      <= lrow_n;
            col       <= ~(4'b0001 << c_n);
            key_valid <= accept;
            if (accept) begin
                key_code <= {r_idx, c};
                key_held <= 1'b1;
                hex3     <= hex2;
                hex2     <= hex1;
                hex1     <= hex0;
                hex0     <= {r_idx, c};
            end else if (rel_done) begin
                key_held <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_hex_keypad_scan.sv
// Directed bench for hex_keypad_scan with a column-gated keypad model.
module tb_hex_keypad_scan;
    localparam int DWELL    = 8;
    localparam int DEBOUNCE = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] col, row, key_code, hex3, hex2, hex1, hex0;
    logic       key_valid, key_held;

    logic       kp_on  = 1'b0;
    logic [1:0] kp_c   = 2'd0;
    logic [3:0] kp_row = 4'hF;

    int nvec = 0;
    int nmis = 0;
    int vcount = 0;

    typedef struct {
        logic [3:0]  rpat;
        logic [1:0]  c;
        logic [3:0]  code;
        logic [15:0] hist;   // {hex3,hex2,hex1,hex0}
    } vec_t;

    vec_t tbl[8];

    hex_keypad_scan #(.DWELL(DWELL), .DEBOUNCE(DEBOUNCE)) dut (
        .clk(clk), .reset(reset), .col(col), .row(row),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held),
        .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] col_pat(input logic [1:0] cc);
        case (cc)
            2'd0: return 4'b1110;
            2'd1: return 4'b1101;
            2'd2: return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    assign row = (kp_on && col == col_pat(kp_c)) ? kp_row : 4'hF;

    always @(negedge clk) if (key_valid === 1'b1) vcount++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst col", col, 4'b1110);
        check("rst code", key_code, 4'h0);
        check("rst valid", key_valid, 1'b0);
        check("rst held", key_held, 1'b0);
        check("rst hist", {hex3, hex2, hex1, hex0}, 16'h0000);
        reset = 1'b1;
    endtask

    task automatic wait_valid(input string name);
        bit found = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) begin
                found = 1;
                break;
            end
        end
        check({name, " valid seen"}, found, 1'b1);
    endtask

    // Release at a negedge: held must survive 18 edges and drop on the 19th.
    task automatic release_check(input string name);
        kp_on = 1'b0;
        repeat (18) @(negedge clk);
        check({name, " held before rel"}, key_held, 1'b1);
        @(negedge clk);
        check({name, " held after rel"}, key_held, 1'b0);
    endtask

    task automatic press_check(input string name, input vec_t v);
        int base;
        base   = vcount;
        kp_row = v.rpat;
        kp_c   = v.c;
        kp_on  = 1'b1;
        wait_valid(name);
        check({name, " code"}, key_code, v.code);
        check({name, " hist"}, {hex3, hex2, hex1, hex0}, v.hist);
        check({name, " held"}, key_held, 1'b1);
        repeat (60) @(negedge clk);
        check({name, " one pulse"}, vcount - base, 1);
        check({name, " code hold"}, key_code, v.code);
        release_check(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{4'b1101, 2'd2, 4'h6, 16'h0006};
        tbl[1] = '{4'b0111, 2'd3, 4'hF, 16'h006F};
        tbl[2] = '{4'b1110, 2'd1, 4'h1, 16'h06F1};
        tbl[3] = '{4'b1110, 2'd2, 4'h2, 16'h6F12};
        tbl[4] = '{4'b1110, 2'd3, 4'h3, 16'h F123};
        tbl[5] = '{4'b1101, 2'd0, 4'h4, 16'h1234};
        tbl[6] = '{4'b1101, 2'd1, 4'h5, 16'h2345};
        tbl[7] = '{4'b1010, 2'd0, 4'h0, 16'h3450};

        // Idle scan: 8 cycles per column, no key activity
        do_reset();
        for (int k = 0; k < 200; k++) begin
            if (k > 0) @(negedge clk);
            check("idle col", col, col_pat(2'((k / 8) % 4)));
            check("idle valid", key_valid, 1'b0);
        end
        check("idle hist", {hex3, hex2, hex1, hex0}, 16'h0000);

        // Bounce on key r=2,c=0: first column-0 decision sees an off phase,
        // the next one (edge 40) latches, debounce completes on edge 56.
        do_reset();
        kp_c   = 2'd0;
        kp_row = 4'b1011;
        for (int k = 0; k <= 80; k++) begin
            if (k > 0) @(negedge clk);
            kp_on = (k >= 30) || (((k / 5) % 2) == 0);
            check("bounce valid", key_valid, (k == 56));
        end
        check("bounce code", key_code, 4'h8);
        check("bounce hex0", hex0, 4'h8);
        check("bounce held", key_held, 1'b1);
        release_check("bounce");

        // Press table: single press, history shift, multi-row priority
        do_reset();
        for (int i = 0; i < 8; i++) begin
            press_check($sformatf("key%0d", i), tbl[i]);
            repeat (5) @(negedge clk);
        end

        // Reset while PRESSED, key still down afterwards
        do_reset();
        kp_row = 4'b1101;
        kp_c   = 2'd3;
        kp_on  = 1'b1;
        wait_valid("midrst pre");
        check("midrst pre code", key_code, 4'h7);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst col", col, 4'b1110);
        check("midrst code", key_code, 4'h0);
        check("midrst valid", key_valid, 1'b0);
        check("midrst held", key_held, 1'b0);
        check("midrst hist", {hex3, hex2, hex1, hex0}, 16'h0000);
        reset = 1'b1;
        wait_valid("midrst post");
        check("midrst post code", key_code, 4'h7);
        check("midrst post hist", {hex3, hex2, hex1, hex0}, 16'h0007);
        check("midrst post held", key_held, 1'b1);
        release_check("midrst");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
